sar_code_averager: RTL
======================

Name: sar_code_averager

Overview:
- Sits directly downstream of the 4-bit SAR logic stage and consumes its `bitout` code and `conv_done` strobe.
- Captures one code per conversion and accumulates 2^LOG2_AVG consecutive codes.
- Emits the rounded average on a valid/ready output port toward the digital back end.
- Flags results that are lost because the consumer stalled.

Parameters:
- CODE_W, 4: width of SAR code.
- LOG2_AVG, 2: log2 of samples per average; legal range 0..6 (0 = pass-through).
- ACC_W, CODE_W+LOG2_AVG: accumulator width; derived, not overridden.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = accept conversions; 0 = idle, discard partial batch.
- code_in  input  CODE_W  SAR result (connects to SAR `bitout`).
- conv_done  input  1  SAR conversion-complete level/pulse.
- avg_code  output  CODE_W  averaged code, held stable while avg_valid=1.
- avg_valid  output  1  avg_code holds an unconsumed result.
- avg_ready  input  1  consumer accepts avg_code this cycle.
- sample_cnt  output  LOG2_AVG (min 1)  samples accumulated in current batch.
- overrun  output  1  sticky: a completed average was dropped.
- clear_ovr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, acc=0, sample_cnt=0.
  - avg_code=0, avg_valid=0, overrun=0.
  - conv_done_q=1, so a conv_done already high at reset release is not counted.
- Edge detect:
  - conv_done_q <= conv_done every cycle, regardless of enable.
  - edge = conv_done & ~conv_done_q.
  - A conv_done held high for N cycles yields exactly one sample.
- Capture: on a clock edge with edge=1 in ACCUM, code_in is sampled that same edge. code_in must be valid while conv_done is high.
- States:
  - IDLE: no capture. Goes to ACCUM when enable=1; the first capturable edge is the cycle after entry.
  - ACCUM, sample with sample_cnt < 2^LOG2_AVG-1: acc += code_in, sample_cnt += 1.
  - ACCUM, sample with sample_cnt = 2^LOG2_AVG-1 (final sample):
    - total = acc + code_in (ACC_W bits, cannot overflow).
    - result = (total + 2^(LOG2_AVG-1)) >> LOG2_AVG, using round-half-up; the rounding term is 0 when LOG2_AVG=0.
    - result saturates to 2^CODE_W-1.
    - acc <= 0, sample_cnt <= 0; the next batch starts immediately with no dead cycle.
  - ACCUM -> IDLE when enable=0: acc and sample_cnt clear next edge. An edge in that cycle is ignored. The output register is untouched.
- Output register:
  - Transfer occurs when avg_valid & avg_ready.
  - Result completes and (avg_valid=0 or transfer this cycle): load avg_code, avg_valid <= 1.
  - Result completes and avg_valid=1 and avg_ready=0: drop the new result, keep the old avg_code, set overrun <= 1.
  - No completion and transfer: avg_valid <= 0. avg_code keeps its last value.
  - avg_valid never deasserts without a transfer or reset.
- Latency: avg_valid/avg_code are visible in the cycle after the clock edge that samples the final edge (1-cycle registered latency).
- overrun is sticky. clear_ovr=1 clears it next edge; a simultaneous set beats clear.
- Reset mid-batch discards everything; no partial result is ever emitted.
- LOG2_AVG=0: every edge produces result = code_in. sample_cnt is tied to 0.

Test Plan:
- LOG2_AVG=2, enable=1, avg_ready=1, codes 3,4,5,6 each with a 3-cycle conv_done pulse -> one avg_valid pulse with avg_code=5 (18+2=20>>2); sample_cnt steps 1,2,3,0.
- Rounding: codes 1,1,1,2 -> avg_code=1; codes 1,2,2,2 -> avg_code=2; codes 15,15,15,15 -> avg_code=15 (62>>2, no wrap).
- Backpressure: avg_ready=0 over two full batches (3,3,3,3 then 9,9,9,9) -> avg_code stays 3, avg_valid stays 1, overrun=1. Then avg_ready=1 -> transfer, avg_valid=0. clear_ovr=1 -> overrun=0.
- Transfer and completion in the same cycle -> avg_valid stays 1, avg_code updates to the new value, overrun stays 0.
- enable dropped after 2 samples, re-raised, then codes 8,8,8,8 -> avg_code=8; partial samples discarded; conv_done held high for 20 cycles counts once.
- conv_done=1 across reset release -> no sample counted. Async reset asserted mid-batch (not aligned to clk) -> all outputs 0 immediately, sample_cnt=0.

Source files
------------

// File: rtl/sar_code_averager_if.sv
// Valid/ready result port from the SAR code averager toward the digital back end.
interface sar_code_averager_if #(
   parameter int CODE_W = 4
);
   logic [CODE_W-1:0] avg_code;
   logic              avg_valid;
   logic              avg_ready;

   modport master (output avg_code, output avg_valid, input avg_ready);
   modport slave  (input avg_code, input avg_valid, output avg_ready);
endinterface

// File: rtl/sar_code_averager.sv
// Averages 2^LOG2_AVG consecutive SAR codes (one per conv_done rising edge) and
// presents the rounded, saturated mean on a valid/ready port with overrun flagging.
module sar_code_averager #(
   parameter  int CODE_W   = 4,
   parameter  int LOG2_AVG = 2,
   localparam int ACC_W    = CODE_W + LOG2_AVG,
   localparam int SC_W     = (LOG2_AVG > 0) ? LOG2_AVG : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [CODE_W-1:0]       code_in,
   input  logic                    conv_done,
   sar_code_averager_if.master     avg,
   output logic [SC_W-1:0]         sample_cnt,
   output logic                    overrun,
   input  logic                    clear_ovr
);

   localparam int              N      = 1 << LOG2_AVG;
   localparam logic [ACC_W:0]  RND    = (ACC_W+1)'((1 << LOG2_AVG) >> 1);
   localparam logic [ACC_W:0]  SAT_TH = (ACC_W+1)'(1) << ACC_W;

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t             state;
   logic [ACC_W-1:0]   acc;
   logic               conv_done_q;
   logic               conv_edge;
   logic               last;
   logic               sample;
   logic               done;
   logic               xfer;
   logic [ACC_W:0]     sum_r;
   logic [CODE_W-1:0]  result;

   assign conv_edge = conv_done & ~conv_done_q;
   assign last      = (sample_cnt == SC_W'(N - 1));
   assign sample    = (state == ACCUM) & enable & conv_edge;
   assign done      = sample & last;
   assign xfer      = avg.avg_valid & avg.avg_ready;

   // Extra top bit keeps the rounding add from wrapping on an all-ones batch.
   assign sum_r  = {1'b0, acc} + (ACC_W+1)'(code_in) + RND;
   assign result = (sum_r >= SAT_TH) ? {CODE_W{1'b1}} : sum_r[ACC_W-1:LOG2_AVG];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         acc           <= '0;
         sample_cnt    <= '0;
         conv_done_q   <= 1'b1;
         avg.avg_code  <= '0;
         avg.avg_valid <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         conv_done_q <= conv_done;

         case (state)
            IDLE: begin
               if (enable) state <= ACCUM;
            end
            ACCUM: begin
               if (!enable) begin
                  state      <= IDLE;
                  acc        <= '0;
                  sample_cnt <= '0;
               end else if (conv_edge) begin
                  if (last) begin
                     acc        <= '0;
                     sample_cnt <= '0;
                  end else begin
                     acc        <= acc + ACC_W'(code_in);
                     sample_cnt <= sample_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // A completion landing on a held, unconsumed result is dropped, not queued.
         if (done && (!avg.avg_valid || xfer)) begin
            avg.avg_code  <= result;
            avg.avg_valid <= 1'b1;
         end else if (xfer) begin
            avg.avg_valid <= 1'b0;
         end

         if (done && avg.avg_valid && !avg.avg_ready) overrun <= 1'b1;
         else if (clear_ovr)                          overrun <= 1'b0;
      end
   end

endmodule
